// File: rtl/md_sequencer_if.sv
// md_sequencer_if: request/result bundle between the ID/EXE pipeline and the
// iterative multiply/divide sequencer. The master side is the pipeline
// (issues requests, consumes stall/status/results); the slave side is the
// sequencer itself.
interface md_sequencer_if #(
  parameter int DW = 32
);
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] srca;
  logic [DW-1:0] srcb;
  logic          mf_req;
  logic          pause;
  logic          multbusy;
  logic          divbusy;
  logic          multover;
  logic          divover;
  logic          hilo_we;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          div0;

  modport master (
    output start, op, srca, srcb, mf_req,
    input  pause, multbusy, divbusy, multover, divover, hilo_we, hi, lo, div0
  );

  modport slave (
    input  start, op, srca, srcb, mf_req,
    output pause, multbusy, divbusy, multover, divover, hilo_we, hi, lo, div0
  );
endinterface

// File: rtl/md_sequencer.sv
// md_sequencer: iterative MULT/MULTU/DIV/DIVU controller for the EXE stage.
// One shared pair of DW-bit accumulators serves as {hi,lo} of the shift-add
// multiplier and as {remainder,quotient} of the restoring divider. Signed ops
// run on magnitudes and get their signs restored in the FIX state.
// Optional feature: define MD_EARLY_TERM_EN to let MUL finish as soon as the
// remaining multiplier bits are all zero (results are unchanged).
module md_sequencer #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input logic           clk,
  input logic           clrn,
  md_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [DW-1:0]   r_accHi, w_accHi;
  logic [DW-1:0]   r_accLo, w_accLo;
  logic [DW-1:0]   r_opnd, w_opnd;
  logic            r_isDiv, w_isDiv;
  logic            r_signA, w_signA;
  logic            r_signB, w_signB;
  logic [DW-1:0]   r_hi, w_hi;
  logic [DW-1:0]   r_lo, w_lo;
  logic            r_div0, w_div0;
`ifdef MD_EARLY_TERM_EN
  logic [DW-1:0]   r_mplr, w_mplr;
  logic [2*DW-1:0] w_shiftAll;
`endif

  logic            w_signedOp, w_sa, w_sb;
  logic [DW-1:0]   w_magA, w_magB;
  logic [DW:0]     w_sum;
  logic [2*DW-1:0] w_shift;
  logic [DW:0]     w_rs;
  logic            w_ge;
  logic [DW-1:0]   w_diff;
  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] w_prodNeg;
  logic            w_active;

  // Operand conditioning: signed ops work on magnitudes, signs kept aside
  assign w_signedOp = ~bus.op[0];
  assign w_sa       = w_signedOp & bus.srca[DW-1];
  assign w_sb       = w_signedOp & bus.srcb[DW-1];
  assign w_magA     = w_sa ? -bus.srca : bus.srca;
  assign w_magB     = w_sb ? -bus.srcb : bus.srcb;

  // Multiply step: conditional add into the upper half, then shift right
  assign w_sum   = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opnd} : {(DW+1){1'b0}});
  assign w_shift = {w_sum, r_accLo[DW-1:1]};

  // Divide step: shift {rem,quo} left and trial-subtract the divisor
  assign w_rs   = {r_accHi, r_accLo[DW-1]};
  assign w_ge   = (w_rs >= {1'b0, r_opnd});
  assign w_diff = w_rs[DW-1:0] - r_opnd;

  assign w_prod    = {r_accHi, r_accLo};
  assign w_prodNeg = -w_prod;

`ifdef MD_EARLY_TERM_EN
  // Remaining iterations would only shift, so do them all at once
  assign w_shiftAll = w_shift >> (r_cnt - CW'(1));
`endif

  assign w_active     = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign bus.pause    = (bus.start | bus.mf_req) & w_active;
  assign bus.multbusy = w_active & ~r_isDiv;
  assign bus.divbusy  = w_active & r_isDiv;
  assign bus.multover = (r_state == S_DONE) & ~r_isDiv;
  assign bus.divover  = (r_state == S_DONE) & r_isDiv;
  assign bus.hilo_we  = (r_state == S_DONE);
  assign bus.div0     = (r_state == S_DONE) & r_div0;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

  // State, datapath and result registers; reset returns to IDLE with all cleared
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_accHi <= '0;
      r_accLo <= '0;
      r_opnd  <= '0;
      r_isDiv <= 1'b0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div0  <= 1'b0;
`ifdef MD_EARLY_TERM_EN
      r_mplr  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_accHi <= w_accHi;
      r_accLo <= w_accLo;
      r_opnd  <= w_opnd;
      r_isDiv <= w_isDiv;
      r_signA <= w_signA;
      r_signB <= w_signB;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
      r_div0  <= w_div0;
`ifdef MD_EARLY_TERM_EN
      r_mplr  <= w_mplr;
`endif
    end
  end

  // Next-state and datapath update; results are captured on the way into DONE
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_accHi = r_accHi;
    w_accLo = r_accLo;
    w_opnd  = r_opnd;
    w_isDiv = r_isDiv;
    w_signA = r_signA;
    w_signB = r_signB;
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_div0  = r_div0;
`ifdef MD_EARLY_TERM_EN
    w_mplr  = r_mplr;
`endif

    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (bus.start) begin
          w_isDiv = bus.op[1];
          w_signA = w_sa;
          w_signB = w_sb;
          w_cnt   = CW'(DW);
          w_accHi = '0;
          if (bus.op[1]) begin
            w_accLo = w_magA;
            w_opnd  = w_magB;
            w_next  = S_DIV;
          end else begin
            w_accLo = w_magB;
            w_opnd  = w_magA;
            w_next  = S_MUL;
          end
`ifdef MD_EARLY_TERM_EN
          w_mplr = w_magB;
`endif
        end
      end

      S_MUL: begin
        w_accHi = w_shift[2*DW-1:DW];
        w_accLo = w_shift[DW-1:0];
        w_cnt   = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_next = S_FIX;
        end
`ifdef MD_EARLY_TERM_EN
        w_mplr = r_mplr >> 1;
        if (r_mplr == '0) begin
          w_accHi = '0;
          w_accLo = '0;
          w_hi    = '0;
          w_lo    = '0;
          w_div0  = 1'b0;
          w_next  = S_DONE;
        end else if ((r_mplr >> 1) == '0) begin
          w_accHi = w_shiftAll[2*DW-1:DW];
          w_accLo = w_shiftAll[DW-1:0];
          w_next  = S_FIX;
        end
`endif
      end

      S_DIV: begin
        if (r_opnd == '0) begin
          w_hi   = r_signA ? -r_accLo : r_accLo;
          w_lo   = '1;
          w_div0 = 1'b1;
          w_next = S_DONE;
        end else begin
          w_accHi = w_ge ? w_diff : w_rs[DW-1:0];
          w_accLo = {r_accLo[DW-2:0], w_ge};
          w_cnt   = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_next = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (r_isDiv) begin
          w_hi = r_signA ? -r_accHi : r_accHi;
          w_lo = (r_signA ^ r_signB) ? -r_accLo : r_accLo;
        end else if (r_signA ^ r_signB) begin
          w_hi = w_prodNeg[2*DW-1:DW];
          w_lo = w_prodNeg[DW-1:0];
        end else begin
          w_hi = r_accHi;
          w_lo = r_accLo;
        end
        w_div0 = 1'b0;
        w_next = S_DONE;
      end

      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table-driven check of md_sequencer results, latency and
// status, plus hand-written stall, back-to-back and mid-operation reset cases.
module tb_md_sequencer;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDiv0;
    int          latFull;
    int          latEt;
  } vec_t;

  logic clk;
  logic clrn;
  int   checks;
  int   failures;
  vec_t vecs[14];

  md_sequencer_if #(.DW(32)) bus ();

  md_sequencer #(.DW(32), .CW(6)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic mf);
    bus.start  = st;
    bus.op     = op;
    bus.srca   = a;
    bus.srcb   = b;
    bus.mf_req = mf;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Sequence driver
  initial begin
    int          cyc;
    int          busyCnt;
    int          expLat;
    int          weCnt;
    int          pauseBad;
    logic [1:0]  opv;
    logic        isDiv;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 34};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 5};
    vecs[2]  = '{2'b01, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F, 1'b0, 34, 4};
    vecs[3]  = '{2'b01, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 34, 2};
    vecs[4]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 34};
    vecs[5]  = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 34, 3};
    vecs[6]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 34, 19};
    vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 34};
    vecs[8]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 2, 2};
    vecs[9]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 34};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0, 34, 34};
    vecs[11] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 34};
    vecs[12] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2, 2};
    vecs[13] = '{2'b11, 32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000, 1'b0, 34, 34};

    // Reset state
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    clrn = 1'b1;
    step();
    step();
    #1;
    checkOutput("reset_status", {bus.pause, bus.multbusy, bus.divbusy, bus.multover,
                                 bus.divover, bus.hilo_we, bus.div0}, 7'b0);
    checkOutput("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    clrn = 1'b0;
    step();

    // Start together with mf_req in IDLE: no stall, start accepted
    applyStimulus(1'b1, 2'b01, 32'h00000005, 32'h00000003, 1'b1);
    #1;
    checkOutput("idle_start_mf_pause", bus.pause, 1'b0);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("idle_start_accepted", bus.multbusy, 1'b1);
    cyc = 1;
    while (!bus.hilo_we && cyc < 100) begin
      step();
      #1;
      cyc++;
    end
    step();
    step();

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      opv   = vecs[i].op;
      isDiv = opv[1];
`ifdef MD_EARLY_TERM_EN
      expLat = vecs[i].latEt;
`else
      expLat = vecs[i].latFull;
`endif
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      step();
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      #1;
      cyc     = 1;
      busyCnt = 0;
      while (!bus.hilo_we && cyc < 100) begin
        if (isDiv ? bus.divbusy : bus.multbusy) busyCnt++;
        step();
        #1;
        cyc++;
      end
      checkOutput($sformatf("v%0d_latency", i), cyc, expLat);
      checkOutput($sformatf("v%0d_busy_cycles", i), busyCnt, expLat - 1);
      checkOutput($sformatf("v%0d_hi", i), bus.hi, vecs[i].expHi);
      checkOutput($sformatf("v%0d_lo", i), bus.lo, vecs[i].expLo);
      checkOutput($sformatf("v%0d_div0", i), bus.div0, vecs[i].expDiv0);
      checkOutput($sformatf("v%0d_over", i), {bus.multover, bus.divover},
                  isDiv ? 2'b01 : 2'b10);
      step();
      step();
      #1;
      checkOutput($sformatf("v%0d_hold", i), {bus.hilo_we, bus.hi, bus.lo},
                  {1'b0, vecs[i].expHi, vecs[i].expLo});
    end

    // Stall and back-to-back issue: second start and mf_req arrive 5 cycles in
    applyStimulus(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    cyc = 1;
    while (cyc < 5) begin
      step();
      cyc++;
    end
    applyStimulus(1'b1, 2'b01, 32'h00000005, 32'h00000003, 1'b1);
    #1;
    pauseBad = 0;
    while (!bus.hilo_we && cyc < 100) begin
      if (!bus.pause) pauseBad++;
      step();
      #1;
      cyc++;
    end
    checkOutput("stall_pause_held", pauseBad, 0);
    checkOutput("stall_done_cycle", cyc, 34);
    checkOutput("stall_done_pause", bus.pause, 1'b0);
    checkOutput("stall_done_result", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("b2b_busy_no_gap", bus.multbusy, 1'b1);
    cyc = 1;
    while (!bus.hilo_we && cyc < 100) begin
      step();
      #1;
      cyc++;
    end
    checkOutput("b2b_result", {bus.hi, bus.lo}, 64'h00000000_0000000F);
    step();
    step();

    // Reset during iteration 10 of a DIVU
    applyStimulus(1'b1, 2'b11, 32'hFFFFFFFF, 32'h0000000A, 1'b0);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    cyc = 1;
    while (cyc < 10) begin
      step();
      cyc++;
    end
    #1;
    checkOutput("mid_div_busy", bus.divbusy, 1'b1);
    clrn = 1'b1;
    step();
    #1;
    checkOutput("mid_reset_status", {bus.pause, bus.multbusy, bus.divbusy, bus.multover,
                                     bus.divover, bus.hilo_we, bus.div0}, 7'b0);
    checkOutput("mid_reset_hilo", {bus.hi, bus.lo}, 64'h0);
    clrn = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    weCnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      if (bus.hilo_we || bus.divover || bus.divbusy) weCnt++;
    end
    checkOutput("mid_reset_no_pulse", weCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Iterative multiply/divide controller in the EXE stage. Accepts MULT/MULTU/DIV/DIVU requests from the ID/EXE pipeline register and runs a shared 32-bit shift-add multiplier / restoring divider datapath.
- Generates the pipeline stall (pause), busy/over status, the HI/LO write strobe and result data. HI/LO results are forwarded to ID and carried to WB.

Parameters:
- DW, 32, operand width; HI and LO are each DW bits.
- CW, 6, iteration counter width; must satisfy 2^CW > DW.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clrn  input  1  reset, synchronous, active-high.
- start  input  1  MD instruction valid in EXE (mdE).
- op  input  2  alu_mdE: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  input  DW  rs operand (multiplicand / dividend).
- srcb  input  DW  rt operand (multiplier / divisor).
- mf_req  input  1  MFHI/MFLO in EXE; stalls if the result is not ready.
- pause  output  1  combinational pipeline stall request (MDPause).
- multbusy  output  1  multiply in progress.
- divbusy  output  1  divide in progress.
- multover  output  1  one-cycle pulse at multiply completion.
- divover  output  1  one-cycle pulse at divide completion.
- hilo_we  output  1  one-cycle HI/LO write strobe (mdcs).
- hi  output  DW  product[63:32] or remainder.
- lo  output  DW  product[31:0] or quotient.
- div0  output  1  divisor was zero; valid with divover.

Behaviour:
- FSM states: IDLE, MUL, DIV, FIX, DONE. Next state is registered. Reset (clrn=1) forces IDLE from any state, including mid-operation.
- Reset values: all outputs 0; counter = 0; accumulators = 0.
- Accepting a request: start=1 in IDLE or DONE latches the operands.
  - Signed ops (MULT, DIV): store |srca|, |srcb| and the sign bits.
  - Unsigned ops: store the raw values.
  - Next state is MUL for op[1]=0, DIV for op[1]=1. Counter loads DW.
- MUL: each cycle, if multiplier LSB = 1, add multiplicand to the upper accumulator. Then shift {carry, acc} right by 1 and decrement the counter. When the counter reaches 1, go to FIX.
- DIV: each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set quo LSB = 1.
  - After DW cycles, go to FIX.
- DIV with srcb = 0: skip iteration and go DIV -> DONE after one cycle. Result hi = srca, lo = all ones, div0 = 1.
- FIX (one cycle), signed ops only:
  - Product is negated (64-bit two's complement) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0, with no trap.
- DONE (one cycle):
  - hilo_we = 1; multover or divover = 1 per op; hi and lo are valid.
  - Next state is IDLE, or MUL/DIV if start=1 in the same cycle (back-to-back issue, no bubble).
- Latency: accept at edge N; DONE spans cycle N+DW+2, i.e. over is asserted 34 cycles after accept for DW=32.
- Busy: multbusy/divbusy = 1 in MUL/DIV/FIX for the active op; 0 in IDLE and DONE.
- Pause: pause = (start | mf_req) & (state ∈ {MUL, DIV, FIX}).
  - A start arriving while busy is not accepted; it is held by the stall and accepted in DONE.
  - mf_req in DONE does not stall; ID consumes the forwarded hi/lo.
- hi/lo hold their last result until the next DONE.
- Simultaneous start and mf_req in IDLE: no stall; start is accepted.

Optional Feature:
- Macro MD_EARLY_TERM_EN.
- Defined: in MUL, for unsigned-magnitude operation, when the remaining multiplier bits are all zero, the datapath performs the pending right shifts in one cycle and jumps to FIX.
  - Total latency becomes (index of highest set multiplier bit + 3) cycles.
  - srcb = 0 reaches DONE 2 cycles after accept.
  - Results are bit-identical to the non-early-termination path.
- Undefined: MUL always runs the full DW iterations. DIV is unaffected in both cases.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> multover and hilo_we pulse 34 cycles after accept; hi = 0xFFFFFFFE, lo = 0x00000001; multbusy high for 33 cycles.
- MULT -3 x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100 / 0 -> divover and div0 = 1 two cycles after accept; hi = 100, lo = 0xFFFFFFFF.
- mf_req and a second start issued 5 cycles after a MULT -> pause = 1 until DONE, then 0. The second op is accepted in DONE, and its busy asserts the next cycle with no idle gap.
- clrn = 1 at iteration 10 of a DIV -> next cycle: state IDLE, all outputs 0, no over/hilo_we pulse.
- With MD_EARLY_TERM_EN: MULTU 5 x 3 -> DONE at cycle 4 after accept, lo = 15, hi = 0. Without it: DONE at cycle 34, same values.
